// File: rtl/regfile_v2_core.sv
// regfile_v2_core: 2-read/1-write register file, r0 hardwired to zero, registered reads with write-first bypass
//   clk, clear (sync active-high reset)
//   addr_rs/req_rs, addr_rt/req_rt: read ports, data on rs/rt one cycle after the request
//   addr_rd/req_rd/wdata: write port, writes to address 0 are dropped
//   reg_zero: high while rs is all zeros
module regfile_v2_core #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [AWIDTH-1:0] addr_rs,
    input  logic [AWIDTH-1:0] addr_rt,
    input  logic [AWIDTH-1:0] addr_rd,
    input  logic              req_rs,
    input  logic              req_rt,
    input  logic              req_rd,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rs,
    output logic [DWIDTH-1:0] rt,
    output logic              reg_zero
);
    localparam int DEPTH = 1 << AWIDTH;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic              wr_en;
    logic              hit_rs;
    logic              hit_rt;
    assign wr_en    = req_rd && (addr_rd != '0);
    assign hit_rs   = wr_en && (addr_rs == addr_rd);
    assign hit_rt   = wr_en && (addr_rt == addr_rd);
    assign reg_zero = (rs == '0);
    // mem[0] is cleared on reset and never written, so it always reads zero
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rs <= '0;
            rt <= '0;
        end else begin
            if (wr_en) mem[addr_rd] <= wdata;
            if (req_rs) rs <= hit_rs ? wdata : mem[addr_rs];
            if (req_rt) rt <= hit_rt ? wdata : mem[addr_rt];
        end
    end
endmodule

// File: tb/tb_regfile_v2_core.sv
// tb_regfile_v2_core: directed self-checking bench for regfile_v2_core
module tb_regfile_v2_core;
    logic        clk = 0;
    logic        clear = 0;
    logic [3:0]  addr_rs = 0;
    logic [3:0]  addr_rt = 0;
    logic [3:0]  addr_rd = 0;
    logic        req_rs = 0;
    logic        req_rt = 0;
    logic        req_rd = 0;
    logic [15:0] wdata = 0;
    logic [15:0] rs;
    logic [15:0] rt;
    logic        reg_zero;
    int checks = 0;
    int errors = 0;

    regfile_v2_core #(.AWIDTH(4), .DWIDTH(16)) dut (
        .clk(clk), .clear(clear),
        .addr_rs(addr_rs), .addr_rt(addr_rt), .addr_rd(addr_rd),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .wdata(wdata), .rs(rs), .rt(rt), .reg_zero(reg_zero)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic c, input logic wr, input logic [3:0] ard, input logic [15:0] wd,
                       input logic e_rs, input logic [3:0] a_rs, input logic e_rt, input logic [3:0] a_rt);
        clear = c; req_rd = wr; addr_rd = ard; wdata = wd;
        req_rs = e_rs; addr_rs = a_rs; req_rt = e_rt; addr_rt = a_rt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc(1, 1, 4'd7, 16'hBEEF, 1, 4'd7, 1, 4'd7);
        cyc(1, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0);
        chk("reset_rs", rs, 16'h0);
        chk("reset_rt", rt, 16'h0);
        chk("reset_zero", {15'b0, reg_zero}, 16'h1);
        cyc(0, 0, 4'd0, 16'h0000, 0, 4'd3, 0, 4'd4);
        chk("idle_rs", rs, 16'h0);
        chk("idle_rt", rt, 16'h0);
        cyc(0, 0, 4'd0, 16'h0000, 1, 4'd7, 1, 4'd7);
        chk("reset_cleared_r7", rt, 16'h0);
        cyc(0, 1, 4'd1, 16'h0001, 0, 4'd0, 0, 4'd0);
        cyc(0, 1, 4'd2, 16'h0002, 0, 4'd0, 0, 4'd0);
        cyc(0, 0, 4'd0, 16'h0000, 1, 4'd1, 1, 4'd2);
        chk("read_r1", rs, 16'h1);
        chk("read_r2", rt, 16'h2);
        chk("zero_low", {15'b0, reg_zero}, 16'h0);
        cyc(0, 0, 4'd0, 16'h0000, 0, 4'd5, 0, 4'd6);
        chk("hold_rs", rs, 16'h1);
        chk("hold_rt", rt, 16'h2);
        cyc(0, 1, 4'd2, 16'h0008, 1, 4'd2, 1, 4'd1);
        chk("bypass_rs", rs, 16'h8);
        chk("nobypass_rt", rt, 16'h1);
        cyc(0, 0, 4'd0, 16'h0000, 1, 4'd2, 0, 4'd0);
        chk("after_bypass_r2", rs, 16'h8);
        cyc(0, 1, 4'd3, 16'h0008, 1, 4'd2, 0, 4'd0);
        chk("diff_addr_rs", rs, 16'h8);
        cyc(0, 1, 4'd4, 16'h00A5, 1, 4'd3, 1, 4'd1);
        chk("diff_addr_r3", rs, 16'h8);
        chk("diff_addr_r1", rt, 16'h1);
        cyc(0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, 4'd3);
        chk("rt_read_r3", rt, 16'h8);
        cyc(0, 1, 4'd5, 16'h5A5A, 1, 4'd5, 1, 4'd5);
        chk("bypass_both_rs", rs, 16'h5A5A);
        chk("bypass_both_rt", rt, 16'h5A5A);
        cyc(0, 0, 4'd1, 16'hFFFF, 1, 4'd4, 1, 4'd1);
        chk("r4_value", rs, 16'h00A5);
        chk("no_wr_keeps_r1", rt, 16'h1);
        cyc(0, 1, 4'd0, 16'hFFFF, 1, 4'd0, 0, 4'd0);
        chk("r0_write_bypass", rs, 16'h0);
        cyc(0, 0, 4'd0, 16'h0000, 1, 4'd0, 1, 4'd0);
        chk("r0_rs", rs, 16'h0);
        chk("r0_rt", rt, 16'h0);
        chk("r0_zero", {15'b0, reg_zero}, 16'h1);
        cyc(0, 0, 4'd0, 16'h0000, 1, 4'd5, 1, 4'd1);
        chk("pre_clear_r5", rs, 16'h5A5A);
        cyc(1, 1, 4'd5, 16'h1234, 1, 4'd5, 1, 4'd5);
        chk("clear_rs", rs, 16'h0);
        chk("clear_rt", rt, 16'h0);
        cyc(0, 0, 4'd0, 16'h0000, 1, 4'd5, 1, 4'd1);
        chk("clear_discards_r5", rs, 16'h0);
        chk("clear_wipes_r1", rt, 16'h0);
        chk("clear_zero", {15'b0, reg_zero}, 16'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_v2_core.md
Name: regfile_v2_core

Overview:
- General-purpose register file for the 16-bit MIPS-style core.
- Two read ports (rs, rt) and one write port (rd); all ports registered on the rising clock edge.
- Register 0 is hardwired to zero.
- Sits between instruction decode (addresses, requests) and the execute stage (operands).

Parameters:
- AWIDTH, 4, register address width; depth = 2**AWIDTH registers (16 by default).
- DWIDTH, 16, register data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous active-high reset.
- addr_rs  input  AWIDTH  read address, port rs.
- addr_rt  input  AWIDTH  read address, port rt.
- addr_rd  input  AWIDTH  write address, port rd.
- req_rs  input  1  read request, port rs.
- req_rt  input  1  read request, port rt.
- req_rd  input  1  write enable, port rd.
- wdata  input  DWIDTH  write data.
- rs  output  DWIDTH  registered read data, port rs.
- rt  output  DWIDTH  registered read data, port rt.
- reg_zero  output  1  high when the rs output is all zeros.

Behaviour:
- Reset: clear sampled high at a rising edge sets all registers, rs and rt to 0, so reg_zero=1.
  - clear has priority over every request in that cycle.
  - Reset mid-operation discards any write in the same cycle.
- Write: at a rising edge with req_rd=1 and clear=0, reg[addr_rd] <= wdata.
  - Writes to address 0 are ignored; reg[0] always reads 0.
  - req_rd=0 leaves all registers unchanged.
- Read rs: at a rising edge with req_rs=1, rs <= reg[addr_rs].
  - With req_rs=0, rs holds its previous value.
  - Latency is one cycle: data is valid after the edge that sampled the request.
- Read rt: same as rs, using req_rt and addr_rt.
- Write-to-read bypass: if req_rd=1, addr_rd!=0 and a read port requests the same address in the same cycle, that port captures wdata (new data, write-first).
  - Different addresses: the read returns the pre-edge content of its address.
- Both read ports may access any address, including the same address, in the same cycle.
- Simultaneous write and reads are all performed in one cycle; there is no stall and no handshake.
- reg_zero is combinational from the registered rs: reg_zero = (rs == 0).
- No X propagation: every register has a defined value after reset.
- Address inputs are full width, so no out-of-range case exists.

Test Plan:
- Reset and idle: hold clear=1 for 2 cycles, then release -> rs=0, rt=0, reg_zero=1; outputs unchanged while all req=0.
- Write/read-back: write r1=1, then r2=2 (req_rd pulses); read rs at addr 1 -> rs=1 one cycle later, reg_zero=0; read rt at addr 2 -> rt=2; drop req -> values held.
- Same-cycle same-address: req_rd=1, addr_rd=2, wdata=8, with req_rs=1, addr_rs=2 -> rs=8 after that edge; a later read of addr 2 returns 8.
- Same-cycle different addresses: req_rd=1, addr_rd=3, wdata=8, with req_rs=1, addr_rs=2 -> rs equals the prior r2 value (8); a subsequent rt read of addr 3 returns 8.
- Register zero: write wdata=16'hFFFF to addr 0, then read rs/rt at addr 0 -> both 0, reg_zero=1.
- Reset priority: assert clear together with a req_rd write of 16'h1234 to addr 5 -> the write is discarded; a later read of addr 5 returns 0.
